// File: rtl/seven_segment_capture_pkg.sv
// ---------------------------------------------------------------------------
// seven_seg_pkg
// Shared constants for the multiplexed 4-digit seven-segment display bus.
// Both the counter display driver and the receive-side capture monitor
// import this package so that the two ends agree on encodings.
//   - SEG_0..SEG_9, SEG_BLANK : active-low cathode patterns, bit 6 = a .. bit 0 = g
//   - AN_DIG3..AN_DIG0, AN_NONE : active-low anode selects, bit 3 = thousands
//   - bcd_t                    : one BCD digit
// ---------------------------------------------------------------------------
package seven_seg_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] AN_DIG3 = 4'b0111;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG0 = 4'b1110;
    localparam logic [3:0] AN_NONE = 4'hF;

endpackage

// File: rtl/seven_segment_capture_decode.sv
// ---------------------------------------------------------------------------
// seven_seg_decode
// Combinational inverse of the display driver's digit encoder.
//   i_pattern : active-low cathodes, bit 6 = a .. bit 0 = g
//   o_bcd     : decoded digit (0 when the pattern is not a digit)
//   o_legal   : 1 when i_pattern is one of the ten digit patterns
// ---------------------------------------------------------------------------
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [3:0] o_bcd,
    output logic       o_legal
);

    always_comb begin
        o_bcd   = 4'd0;
        o_legal = 1'b1;
        case (i_pattern)
            SEG_0:   o_bcd = 4'd0;
            SEG_1:   o_bcd = 4'd1;
            SEG_2:   o_bcd = 4'd2;
            SEG_3:   o_bcd = 4'd3;
            SEG_4:   o_bcd = 4'd4;
            SEG_5:   o_bcd = 4'd5;
            SEG_6:   o_bcd = 4'd6;
            SEG_7:   o_bcd = 4'd7;
            SEG_8:   o_bcd = 4'd8;
            SEG_9:   o_bcd = 4'd9;
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_segment_capture.sv
// ---------------------------------------------------------------------------
// seven_segment_capture
// Receive-side monitor for the multiplexed 4-digit seven-segment bus.
// Each {anode, segment} pair must stay unchanged for SETTLE_CYCLES cycles
// before it is sampled; sampled digits are collected per position and a full
// 4-digit BCD frame is published once every position has been seen.
//   clk             : system clock
//   rst_n           : asynchronous reset, active-high (1 = in reset)
//   i_anode_sel     : active-low digit select, bit 3 = thousands
//   i_seven_segment : active-low cathodes, bit 6 = a .. bit 0 = g
//   i_clear_err     : clears both sticky error flags
//   o_bcd           : last complete frame, [15:12] thousands .. [3:0] units
//   o_valid         : one-cycle pulse when o_bcd updates
//   o_digits_seen   : positions captured in the current partial frame
//   o_err_pattern   : sticky, a settled pattern was not a legal digit
//   o_err_anode     : sticky, a settled anode had more than one digit active
// ---------------------------------------------------------------------------
module seven_segment_capture
    import seven_seg_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  i_anode_sel,
    input  logic [6:0]  i_seven_segment,
    input  logic        i_clear_err,
    output logic [15:0] o_bcd,
    output logic        o_valid,
    output logic [3:0]  o_digits_seen,
    output logic        o_err_pattern,
    output logic        o_err_anode
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SETTLE_CYCLES - 1);

    logic [10:0]      in_q, in_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       seen_q, seen_d;
    logic [15:0]      bcd_q, bcd_d;
    logic             valid_q, valid_d;
    logic             err_pattern_q, err_pattern_d;
    logic             err_anode_q, err_anode_d;
    bcd_t             digit_q [4];
    bcd_t             digit_d [4];

    logic [3:0] anode;
    logic [6:0] segs;
    logic       sample;
    logic [3:0] new_bit;
    logic [3:0] dec_bcd;
    logic       dec_legal;

    assign anode  = in_q[10:7];
    assign segs   = in_q[6:0];
    // Saturation at SETTLE_CYCLES guarantees this matches once per dwell.
    assign sample = (cnt_q == CNT_SAMPLE);

    seven_seg_decode u_decode (
        .i_pattern (segs),
        .o_bcd     (dec_bcd),
        .o_legal   (dec_legal)
    );

    always_comb begin
        in_d          = {i_anode_sel, i_seven_segment};
        seen_d        = seen_q;
        bcd_d         = bcd_q;
        valid_d       = 1'b0;
        err_pattern_d = i_clear_err ? 1'b0 : err_pattern_q;
        err_anode_d   = i_clear_err ? 1'b0 : err_anode_q;
        new_bit       = ~anode;
        for (int i = 0; i < 4; i++) begin
            digit_d[i] = digit_q[i];
        end

        // Comparing the incoming pair against the held one makes the counter
        // read 0 in the first cycle the new pair is registered.
        if (in_d != in_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        if (sample) begin
            case (anode)
                AN_NONE: ;
                AN_DIG3, AN_DIG2, AN_DIG1, AN_DIG0: begin
                    if (dec_legal) begin
                        for (int i = 0; i < 4; i++) begin
                            if (new_bit[i]) digit_d[i] = dec_bcd;
                        end
                        // Frame includes the digit captured in this very event.
                        if ((seen_q | new_bit) == 4'hF) begin
                            bcd_d   = {digit_d[3], digit_d[2], digit_d[1], digit_d[0]};
                            valid_d = 1'b1;
                            seen_d  = 4'h0;
                        end else begin
                            seen_d  = seen_q | new_bit;
                        end
                    end else begin
                        // A new error outranks a simultaneous clear.
                        err_pattern_d = 1'b1;
                    end
                end
                default: err_anode_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            in_q          <= '1;
            cnt_q         <= '0;
            seen_q        <= 4'h0;
            bcd_q         <= 16'h0;
            valid_q       <= 1'b0;
            err_pattern_q <= 1'b0;
            err_anode_q   <= 1'b0;
        end else begin
            in_q          <= in_d;
            cnt_q         <= cnt_d;
            seen_q        <= seen_d;
            bcd_q         <= bcd_d;
            valid_q       <= valid_d;
            err_pattern_q <= err_pattern_d;
            err_anode_q   <= err_anode_d;
        end
    end

    // Digit storage needs no reset: seen clears on reset, so every position is
    // rewritten before any frame can be published from it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            digit_q[i] <= digit_d[i];
        end
    end

    assign o_bcd         = bcd_q;
    assign o_valid       = valid_q;
    assign o_digits_seen = seen_q;
    assign o_err_pattern = err_pattern_q;
    assign o_err_anode   = err_anode_q;

endmodule

// File: tb/tb_seven_segment_capture.sv
module tb_seven_segment_capture;
    import seven_seg_pkg::*;

    localparam int S    = 1024;
    localparam int HOLD = 2000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  i_anode_sel;
    logic [6:0]  i_seven_segment;
    logic        i_clear_err;
    logic [15:0] o_bcd;
    logic        o_valid;
    logic [3:0]  o_digits_seen;
    logic        o_err_pattern;
    logic        o_err_anode;

    int n_tests  = 0;
    int n_failed = 0;
    int n_valid  = 0;
    logic [15:0] exp_q [$];

    seven_segment_capture #(.SETTLE_CYCLES(S)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_anode_sel     (i_anode_sel),
        .i_seven_segment (i_seven_segment),
        .i_clear_err     (i_clear_err),
        .o_bcd           (o_bcd),
        .o_valid         (o_valid),
        .o_digits_seen   (o_digits_seen),
        .o_err_pattern   (o_err_pattern),
        .o_err_anode     (o_err_anode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int cycles);
        i_anode_sel     = an;
        i_seven_segment = seg;
        tick(cycles);
    endtask

    // Scoreboard: every published frame is matched against the oldest expectation.
    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            n_valid++;
            if (exp_q.size() == 0) check("unexpected_valid", {16'h0, o_bcd}, 32'hFFFF_FFFF);
            else check("frame", {16'h0, o_bcd}, {16'h0, exp_q.pop_front()});
        end
    end

    initial begin
        rst_n           = 1'b1;
        i_anode_sel     = AN_NONE;
        i_seven_segment = SEG_BLANK;
        i_clear_err     = 1'b0;
        tick(4);
        check("rst_bcd",   {16'h0, o_bcd}, 32'h0);
        check("rst_valid", {31'h0, o_valid}, 32'h0);
        check("rst_seen",  {28'h0, o_digits_seen}, 32'h0);
        check("rst_errp",  {31'h0, o_err_pattern}, 32'h0);
        check("rst_erra",  {31'h0, o_err_anode}, 32'h0);
        rst_n = 1'b0;
        tick(2);

        // Basic frame 1234 with exact o_valid timing on the last digit.
        exp_q.push_back(16'h1234);
        drive(AN_DIG3, SEG_1, HOLD);
        check("seen_after_d3", {28'h0, o_digits_seen}, 32'h8);
        drive(AN_DIG2, SEG_2, HOLD);
        check("seen_after_d2", {28'h0, o_digits_seen}, 32'hC);
        drive(AN_DIG1, SEG_3, HOLD);
        check("seen_after_d1", {28'h0, o_digits_seen}, 32'hE);
        drive(AN_DIG0, SEG_4, S);
        check("valid_early", {31'h0, o_valid}, 32'h0);
        check("seen_before", {28'h0, o_digits_seen}, 32'hE);
        tick(1);
        check("valid_on_time", {31'h0, o_valid}, 32'h1);
        check("bcd_1234", {16'h0, o_bcd}, 32'h1234);
        check("seen_cleared", {28'h0, o_digits_seen}, 32'h0);
        tick(1);
        check("valid_one_cycle", {31'h0, o_valid}, 32'h0);
        tick(HOLD - S - 2);

        // Glitch rejection: short dwell is never sampled.
        drive(AN_DIG1, SEG_5, 500);
        drive(AN_NONE, SEG_BLANK, HOLD);
        check("glitch_seen", {28'h0, o_digits_seen}, 32'h0);
        check("glitch_errp", {31'h0, o_err_pattern}, 32'h0);
        check("glitch_erra", {31'h0, o_err_anode}, 32'h0);

        // Illegal segment pattern.
        drive(AN_DIG0, 7'b1111110, HOLD);
        check("pat_errp", {31'h0, o_err_pattern}, 32'h1);
        check("pat_seen0", {31'h0, o_digits_seen[0]}, 32'h0);
        check("pat_erra", {31'h0, o_err_anode}, 32'h0);
        i_clear_err = 1'b1;
        tick(1);
        i_clear_err = 1'b0;
        check("pat_cleared", {31'h0, o_err_pattern}, 32'h0);

        // Multiple anodes active, clear, then clear colliding with a new error.
        drive(4'b0011, SEG_8, HOLD);
        check("an_erra", {31'h0, o_err_anode}, 32'h1);
        check("an_seen", {28'h0, o_digits_seen}, 32'h0);
        i_clear_err = 1'b1;
        tick(1);
        i_clear_err = 1'b0;
        check("an_cleared", {31'h0, o_err_anode}, 32'h0);
        drive(4'b0101, SEG_8, S);
        check("an_pre_collide", {31'h0, o_err_anode}, 32'h0);
        i_clear_err = 1'b1;
        tick(1);
        i_clear_err = 1'b0;
        check("an_error_wins", {31'h0, o_err_anode}, 32'h1);
        tick(HOLD - S - 1);

        // Partial frame then reset mid-dwell: everything returns to zero.
        drive(AN_DIG3, SEG_5, HOLD);
        drive(AN_DIG2, SEG_5, HOLD);
        drive(AN_DIG1, SEG_5, HOLD);
        check("partial_seen", {28'h0, o_digits_seen}, 32'hE);
        drive(AN_DIG0, SEG_3, 100);
        rst_n           = 1'b1;
        i_anode_sel     = AN_NONE;
        i_seven_segment = SEG_BLANK;
        tick(3);
        check("mid_rst_bcd",  {16'h0, o_bcd}, 32'h0);
        check("mid_rst_seen", {28'h0, o_digits_seen}, 32'h0);
        check("mid_rst_erra", {31'h0, o_err_anode}, 32'h0);
        check("mid_rst_errp", {31'h0, o_err_pattern}, 32'h0);
        check("mid_rst_valid", {31'h0, o_valid}, 32'h0);
        rst_n = 1'b0;
        tick(2);
        exp_q.push_back(16'h9876);
        drive(AN_DIG3, SEG_9, HOLD);
        check("fresh_seen", {28'h0, o_digits_seen}, 32'h8);
        drive(AN_DIG2, SEG_8, HOLD);
        drive(AN_DIG1, SEG_7, HOLD);
        drive(AN_DIG0, SEG_6, HOLD);
        check("bcd_9876", {16'h0, o_bcd}, 32'h9876);

        // Recapture of a position within one frame overwrites it.
        exp_q.push_back(16'h7001);
        drive(AN_DIG3, SEG_2, HOLD);
        drive(AN_DIG3, SEG_7, HOLD);
        check("recap_seen", {28'h0, o_digits_seen}, 32'h8);
        drive(AN_DIG2, SEG_0, HOLD);
        drive(AN_DIG1, SEG_0, HOLD);
        drive(AN_DIG0, SEG_1, HOLD);
        check("bcd_7001", {16'h0, o_bcd}, 32'h7001);
        drive(AN_NONE, SEG_BLANK, HOLD);

        check("valid_count", n_valid, 32'd3);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule

// File: doc/seven_segment_capture.md
# seven_segment_capture

Receive-side monitor for the multiplexed 4-digit seven-segment display bus. It watches the active-low anode-select and cathode lines and waits for each pattern to settle. Each settled pattern is decoded back to a BCD digit, and a complete 4-digit BCD value is published once every digit position has been captured. It sits on the display bus as a self-check and loopback block for the counter display driver.

## Interface
- SETTLE_CYCLES, default 1024: number of consecutive cycles an {anode, segment} pair must stay unchanged before it is sampled. Minimum 2.
- clk  input  1: system clock (100 MHz).
- rst_n  input  1: reset, asynchronous, active-high (asserted = 1).
- i_anode_sel  input  4: active-low digit select. Bit 3 = leftmost digit (thousands), bit 0 = rightmost (units).
- i_seven_segment  input  7: active-low cathodes, bit 6 = a … bit 0 = g.
- i_clear_err  input  1: clears both sticky error flags.
- o_bcd  output  16: last complete frame. [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units.
- o_valid  output  1: one-cycle pulse when o_bcd is updated.
- o_digits_seen  output  4: positions captured in the current partial frame. Bit mapping is the same as i_anode_sel.
- o_err_pattern  output  1: sticky flag, a settled segment pattern was not a legal digit.
- o_err_anode  output  1: sticky flag, a settled anode value had more than one digit active.

## Operation
- Input stage: {i_anode_sel, i_seven_segment} is registered once. Reset value is all ones (blank).
- Stability counter:
  - Resets to 0 on any cycle where the registered pair differs from its previous value.
  - Otherwise increments, saturating at SETTLE_CYCLES.
  - A sample event fires for exactly one cycle, when the counter equals SETTLE_CYCLES-1. This gives one event per stable dwell.
- On a sample event, classify the anode value:
  - 4'b1111 (no digit active): ignored, no error.
  - Exactly one zero: decode the segment pattern.
  - Any other value: set o_err_anode, capture nothing.
- Decode table, active-low a..g:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
  - Any other pattern: set o_err_pattern, capture nothing, seen bit unchanged.
- Legal digit: write the digit register for that position and set its seen bit. Recapturing a position already seen in the current frame overwrites the value.
- Frame completion:
  - Completion occurs when (seen | new_bit) == 4'b1111.
  - On completion: o_bcd loads all four digit registers, including the digit captured in this event. o_valid pulses and seen clears to 0.
- Error flags:
  - i_clear_err clears both flags.
  - If a new error and i_clear_err occur in the same cycle, the flag is set (error wins).
- Reset (any time, including mid-frame): o_bcd = 0, o_valid = 0, o_digits_seen = 0, both error flags = 0, counter = 0, input register = all ones. A partial frame is discarded.

## Timing
- Latency from an input change to its capture:
  - Input changes before edge t and is registered at t; counter = 0 in cycle t.
  - Sample event occurs in cycle t+SETTLE_CYCLES-1.
  - Captured digit, o_digits_seen, error flags, o_bcd and o_valid update at edge t+SETTLE_CYCLES.
- o_valid is high for exactly one cycle per completed frame. Back-to-back frames are separated by at least 4×SETTLE_CYCLES cycles.
- A pair that changes before reaching SETTLE_CYCLES-1 stable cycles is never sampled (glitch rejection).
- A pair held indefinitely produces exactly one sample event.
- All outputs are registered. No combinational path from inputs to outputs.
- Counter width: $clog2(SETTLE_CYCLES+1).

## Structure
- Package seven_seg_pkg holds:
  - Ten active-low segment pattern constants (SEG_0..SEG_9) and SEG_BLANK = 7'h7F.
  - Anode constants AN_DIG3..AN_DIG0 (0111, 1011, 1101, 1110) and AN_NONE = 4'hF.
  - A shared typedef for 4-bit BCD.
  - The display driver and this block both import it.
- One sub-module, seven_seg_decode: combinational, 7-bit pattern in, 4-bit BCD plus legal flag out. Instantiated once.
- Top level contains the input register, stability counter, anode classifier, digit registers, seen mask and error flags.

## Test plan
- Reset, then drive digits 1, 2, 3, 4 at AN_DIG3..AN_DIG0, each held 2000 cycles -> o_bcd = 16'h1234. o_valid pulses once, SETTLE_CYCLES cycles after the last digit is registered.
- Hold digit 5 on AN_DIG1 for 500 cycles, then change it -> no capture, o_digits_seen unchanged, no errors.
- Drive pattern 7'b1111110 on AN_DIG0 for 2000 cycles -> o_err_pattern = 1, o_digits_seen[0] = 0, no o_valid.
- Drive anode 4'b0011 for 2000 cycles -> o_err_anode = 1. Then pulse i_clear_err -> o_err_anode = 0. Assert i_clear_err in the same cycle as a new anode error -> flag stays 1.
- Capture three digits (o_digits_seen = 4'b1110), then assert rst_n mid-dwell -> all outputs 0. A fresh full frame 9,8,7,6 is required to give o_bcd = 16'h9876.
- Recapture AN_DIG3 with 2 then 7 before the frame completes, then finish the frame with 0,0,1 -> o_bcd = 16'h7001.
